// File: rtl/alu_exec.sv
// alu_exec: execution-side ALU behind a valid/ready handshake.
//
// Operations come in from the register-read stage with the 4-bit ALU control
// code produced by the ALU control decoder. AND/OR/ADD/SUB/SLT finish in one
// cycle. SLL/SRL/SRA shift iteratively, one bit per cycle. The registered
// result and its zero flag go to writeback and to branch resolution.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operands and aluCtl are valid this cycle
//   in_ready   unit can accept an operation (state == IDLE)
//   aluCtl     operation code (decoder encoding; unknown codes execute as ADD)
//   a, b       operands; b[SHAMT_W-1:0] is the shift amount for shifts
//   out_valid  result/zero valid (state == DONE)
//   out_ready  consumer takes the result this cycle
//   result     registered result
//   zero       registered (result == 0)
//   busy       high whenever state != IDLE
module alu_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         aluCtl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               busy
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_t;

    state_t             state, state_next;
    shift_t             shift_kind, shift_kind_in;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_shifted;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_value;
    logic               is_shift;
    logic               accept;
    logic               slt_bit;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    // Upper bits of b are deliberately ignored for the shift amount.
    assign shamt   = b[SHAMT_W-1:0];
    assign slt_bit = ($signed(a) < $signed(b));

    // Single-cycle operations and shift-type decode.
    // NOTE: every output of a combinational block gets a default before the
    // case; a path that leaves one unassigned would infer a latch.
    always_comb begin
        alu_value     = a + b;
        is_shift      = 1'b0;
        shift_kind_in = SH_SLL;
        case (aluCtl)
            OP_AND: alu_value = a & b;
            OP_OR:  alu_value = a | b;
            OP_ADD: alu_value = a + b;
            OP_SUB: alu_value = a - b;
            OP_SLT: alu_value = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLL: begin
                is_shift      = 1'b1;
                shift_kind_in = SH_SLL;
            end
            OP_SRL: begin
                is_shift      = 1'b1;
                shift_kind_in = SH_SRL;
            end
            OP_SRA: begin
                is_shift      = 1'b1;
                shift_kind_in = SH_SRA;
            end
            default: alu_value = a + b;
        endcase
    end

    // One-bit step of the iterative shifter.
    always_comb begin
        acc_shifted = acc;
        case (shift_kind)
            SH_SLL:  acc_shifted = {acc[WIDTH-2:0], 1'b0};
            SH_SRL:  acc_shifted = {1'b0, acc[WIDTH-1:1]};
            SH_SRA:  acc_shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: acc_shifted = acc;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) state_next = SHIFT;
                    else                           state_next = DONE;
                end
            end
            // cnt never reaches 0 while in SHIFT; <= keeps a stray 0 from
            // spinning through a full wrap-around.
            SHIFT:   if (cnt <= CNT_ONE) state_next = DONE;
            DONE:    if (out_ready)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Datapath registers. Operands are sampled only on the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            cnt        <= '0;
            shift_kind <= SH_SLL;
            result     <= '0;
            zero       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_shift) begin
                            result <= alu_value;
                            zero   <= (alu_value == '0);
                        end else if (shamt == '0) begin
                            result <= a;
                            zero   <= (a == '0);
                        end else begin
                            acc        <= a;
                            cnt        <= shamt;
                            shift_kind <= shift_kind_in;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_shifted;
                    cnt <= cnt - CNT_ONE;
                    if (cnt <= CNT_ONE) begin
                        result <= acc_shifted;
                        zero   <= (acc_shifted == '0);
                    end
                end
                default: ;  // DONE holds result/zero until taken
            endcase
        end
    end

endmodule
